// File: rtl/fpumul_pipe_pkg.sv
// Shared floating-point definitions for the multiplier pipeline: exception bit
// indices, control-word flag positions, rounding-mode codes and exponent codes.
package fpumul_pipe_pkg;

    localparam int RAISE_W = 11;

    // Bit positions inside raise/sticky
    localparam int csrfpu_inexact_excpt = 0;
    localparam int csrfpu_under_excpt   = 1;
    localparam int csrfpu_over_excpt    = 2;
    localparam int csrfpu_divz_excpt    = 3;
    localparam int csrfpu_inv_excpt     = 4;

    // Bit position inside the captured control word
    localparam int csrfpu_inv_flag = 4;

    typedef enum logic [2:0] {
        RM_TRUNC         = 3'd0,
        RM_NEAR_AWAY     = 3'd1,
        RM_NEAR_EVEN     = 3'd2,
        RM_POS_INF       = 3'd3,
        RM_NEG_INF       = 3'd4,
        RM_AWAY          = 3'd5,
        RM_TRUNC_ALT     = 3'd6,
        RM_NEAR_EVEN_ALT = 3'd7
    } rmode_e;

    function automatic int fp_bias(input int expw);
        return (1 << (expw - 1)) - 1;
    endfunction

    function automatic int fp_inf_code(input int expw);
        return (1 << expw) - 2;
    endfunction

    function automatic int fp_nan_code(input int expw);
        return (1 << expw) - 1;
    endfunction

endpackage

// File: rtl/fpumul_round.sv
// Mantissa rounding: decides the increment from guard/sticky, sign and mode,
// and reports the carry out of the stored mantissa.
module fpumul_round
    import fpumul_pipe_pkg::*;
#(
    parameter int MANW = 23
)(
    input  logic [MANW-1:0] man,
    input  logic            g,
    input  logic            s,
    input  logic            sign,
    input  logic [2:0]      rmode,
    output logic [MANW-1:0] man_out,
    output logic            carry
);

    logic inc;

    // Rounding increment per mode; truncating modes fall to the default
    always_comb begin
        inc = 1'b0;
        case (rmode_e'(rmode))
            RM_NEAR_AWAY:                   inc = g;
            RM_NEAR_EVEN, RM_NEAR_EVEN_ALT: inc = g & (s | man[0]);
            RM_POS_INF:                     inc = ~sign & (g | s);
            RM_NEG_INF:                     inc = sign & (g | s);
            RM_AWAY:                        inc = g | s;
            default:                        inc = 1'b0;
        endcase
    end

    assign {carry, man_out} = {1'b0, man} + (MANW + 1)'(inc);

endmodule

// File: rtl/fpumul_pipe.sv
// Pipelined floating-point multiplier. Stage 0 captures the operands with
// their rounding mode and control flag; the product is formed behaviourally
// after stage 0 and carried through LAT-1 result stages so that synthesis can
// retime the multiplier array across them. All stages stall together.
module fpumul_pipe
    import fpumul_pipe_pkg::*;
#(
    parameter  int EXPW = 9,
    parameter  int MANW = 23,
    parameter  int LAT  = 3,
    localparam int W    = 1 + EXPW + MANW
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [W-1:0]       A,
    input  logic [W-1:0]       B,
    input  logic               copyA,
    input  logic [2:0]         rmode,
    input  logic [31:0]        fpcsr,
    input  logic               flush,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [W-1:0]       res,
    output logic [RAISE_W-1:0] raise,
    output logic [RAISE_W-1:0] sticky,
    input  logic               sticky_clr
);

    localparam int EW = EXPW + 2;
    localparam int PW = 2 * (MANW + 1);
    localparam int NR = LAT - 1;

    localparam logic [EW-1:0]   BIAS_E      = EW'(fp_bias(EXPW));
    localparam logic [EW-1:0]   INF_E       = EW'(fp_inf_code(EXPW));
    localparam logic [EXPW-1:0] INF_C       = EXPW'(fp_inf_code(EXPW));
    localparam logic [EXPW-1:0] NAN_C       = EXPW'(fp_nan_code(EXPW));
    localparam logic [MANW-1:0] NAN_MAN_INV = MANW'(1);
    localparam logic [MANW-1:0] NAN_MAN_Q   = MANW'(1) | (MANW'(1) << (MANW - 1));

    logic adv;
    assign adv    = ~out_vld | out_rdy;
    assign in_rdy = adv;

    // Only the invalid-flag bit of the control word affects the result
    logic unused_fpcsr;
    assign unused_fpcsr = ^fpcsr;

    logic         s0_vld;
    logic [W-1:0] s0_a;
    logic [W-1:0] s0_b;
    logic         s0_copy;
    logic [2:0]   s0_rmode;
    logic         s0_inv;

    // Stage 0: capture operands together with their mode and flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld   <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
            s0_copy  <= 1'b0;
            s0_rmode <= '0;
            s0_inv   <= 1'b0;
        end else if (flush) begin
            s0_vld <= 1'b0;
        end else if (adv) begin
            s0_vld   <= in_vld;
            s0_a     <= A;
            s0_b     <= B;
            s0_copy  <= copyA;
            s0_rmode <= rmode;
            s0_inv   <= fpcsr[csrfpu_inv_flag];
        end
    end

    logic            sa, sb, sign;
    logic [EXPW-1:0] ea, eb;
    logic [MANW-1:0] ma, mb;

    assign {sa, ea, ma} = s0_a;
    assign {sb, eb, mb} = s0_b;
    assign sign         = sa ^ sb;

    logic a_zero, b_zero, a_inf, b_inf, is_nan;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == INF_C);
    assign b_inf  = (eb == INF_C);
    assign is_nan = (ea == NAN_C) | (eb == NAN_C) | (a_inf & b_zero) | (a_zero & b_inf);

    logic [PW-1:0]   prod, prod_n;
    logic            norm, grd, stk;
    logic [MANW-1:0] frac, man_rnd;
    logic            rnd_carry;

    assign prod   = {{(MANW + 1){1'b0}}, 1'b1, ma} * {{(MANW + 1){1'b0}}, 1'b1, mb};
    assign norm   = prod[PW-1];
    assign prod_n = norm ? (prod >> 1) : prod;
    assign frac   = prod_n[PW-3 -: MANW];
    assign grd    = prod_n[MANW-1];
    // The bit dropped by normalisation still counts toward sticky
    assign stk    = (|prod_n[MANW-2:0]) | (norm & prod[0]);

    fpumul_round #(.MANW(MANW)) u_round (
        .man     (frac),
        .g       (grd),
        .s       (stk),
        .sign    (sign),
        .rmode   (s0_rmode),
        .man_out (man_rnd),
        .carry   (rnd_carry)
    );

    logic [EW-1:0] exp_u;
    logic          ovf, unf;

    assign exp_u = {2'b00, ea} + {2'b00, eb} - BIAS_E + EW'(norm) + EW'(rnd_carry);
    assign ovf   = ~exp_u[EW-1] & (exp_u >= INF_E);
    assign unf   = exp_u[EW-1] | (exp_u == '0);

    logic [W-1:0]       r_res;
    logic [RAISE_W-1:0] r_raise;

    // Result select: copy beats specials, specials beat range checks
    always_comb begin
        r_res   = {sign, exp_u[EXPW-1:0], man_rnd};
        r_raise = '0;
        r_raise[csrfpu_inexact_excpt] = grd | stk;
        if (s0_copy) begin
            r_res   = s0_a;
            r_raise = '0;
        end else if (is_nan) begin
            r_raise = '0;
            if (s0_inv) begin
                r_res = {1'b1, NAN_C, NAN_MAN_INV};
                r_raise[csrfpu_inv_excpt] = 1'b1;
            end else begin
                r_res = {1'b1, NAN_C, NAN_MAN_Q};
            end
        end else if (a_inf | b_inf) begin
            r_res   = {sign, INF_C, {MANW{1'b0}}};
            r_raise = '0;
        end else if (a_zero | b_zero) begin
            r_res   = {sign, {EXPW{1'b0}}, {MANW{1'b0}}};
            r_raise = '0;
        end else if (ovf) begin
            r_res   = {sign, INF_C, {MANW{1'b0}}};
            r_raise = '0;
            r_raise[csrfpu_over_excpt]    = 1'b1;
            r_raise[csrfpu_inexact_excpt] = 1'b1;
        end else if (unf) begin
            r_res   = {sign, {EXPW{1'b0}}, {MANW{1'b0}}};
            r_raise = '0;
            r_raise[csrfpu_under_excpt]   = 1'b1;
            r_raise[csrfpu_inexact_excpt] = 1'b1;
        end
    end

    logic [NR-1:0]      p_vld;
    logic [W-1:0]       p_res   [NR];
    logic [RAISE_W-1:0] p_raise [NR];

    // Result stages: shift together on adv, valid bits cleared by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_vld <= '0;
            for (int i = 0; i < NR; i++) begin
                p_res[i]   <= '0;
                p_raise[i] <= '0;
            end
        end else if (flush) begin
            p_vld <= '0;
        end else if (adv) begin
            p_vld[0]   <= s0_vld;
            p_res[0]   <= r_res;
            p_raise[0] <= r_raise;
            for (int i = 1; i < NR; i++) begin
                p_vld[i]   <= p_vld[i-1];
                p_res[i]   <= p_res[i-1];
                p_raise[i] <= p_raise[i-1];
            end
        end
    end

    assign out_vld = p_vld[NR-1];
    assign res     = p_res[NR-1];
    assign raise   = p_raise[NR-1];

    // Accumulate exceptions of consumed results; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky <= '0;
        end else if (sticky_clr) begin
            sticky <= '0;
        end else if (out_vld & out_rdy) begin
            sticky <= sticky | raise;
        end
    end

endmodule

// File: tb/tb_fpumul_pipe.sv
// Directed bench for fpumul_pipe at EXPW=9, MANW=23, LAT=3.
module tb_fpumul_pipe;
    import fpumul_pipe_pkg::*;

    localparam logic [10:0] RX = 11'(1) << csrfpu_inexact_excpt;
    localparam logic [10:0] RO = (11'(1) << csrfpu_over_excpt) | RX;
    localparam logic [10:0] RU = (11'(1) << csrfpu_under_excpt) | RX;
    localparam logic [10:0] RI = 11'(1) << csrfpu_inv_excpt;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [32:0] A, B;
    logic        copyA;
    logic [2:0]  rmode;
    logic [31:0] fpcsr;
    logic        flush;
    logic        out_vld;
    logic        out_rdy;
    logic [32:0] res;
    logic [10:0] raise;
    logic [10:0] sticky;
    logic        sticky_clr;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] exp_sticky = '0;

    fpumul_pipe #(.EXPW(9), .MANW(23), .LAT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .A          (A),
        .B          (B),
        .copyA      (copyA),
        .rmode      (rmode),
        .fpcsr      (fpcsr),
        .flush      (flush),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .res        (res),
        .raise      (raise),
        .sticky     (sticky),
        .sticky_clr (sticky_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One op through an otherwise idle pipe: exact latency, result, then consume
    task automatic run_op(input string tag, input logic [32:0] a, input logic [32:0] b,
                          input logic [2:0] rm, input logic inv, input logic cp,
                          input logic [32:0] eres, input logic [10:0] eraise, input logic clr);
        A      = a;
        B      = b;
        rmode  = rm;
        fpcsr  = 32'(inv) << csrfpu_inv_flag;
        copyA  = cp;
        in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        A      = '0;
        B      = '0;
        rmode  = 3'd0;
        fpcsr  = '0;
        copyA  = 1'b0;
        step();
        chk({tag, "_early"}, 64'(out_vld), 64'(0));
        step();
        chk({tag, "_vld"}, 64'(out_vld), 64'(1));
        chk({tag, "_res"}, 64'(res), 64'(eres));
        chk({tag, "_raise"}, 64'(raise), 64'(eraise));
        sticky_clr = clr;
        step();
        sticky_clr = 1'b0;
        exp_sticky = clr ? 11'd0 : (exp_sticky | eraise);
        chk({tag, "_gone"}, 64'(out_vld), 64'(0));
        chk({tag, "_sticky"}, 64'(sticky), 64'(exp_sticky));
    endtask

    initial begin
        int          k;
        int          got;
        logic        acc;
        logic        held_v;
        logic [32:0] held_res;

        rst = 1'b1; in_vld = 1'b0; A = '0; B = '0; copyA = 1'b0; rmode = '0;
        fpcsr = '0; flush = 1'b0; out_rdy = 1'b1; sticky_clr = 1'b0;
        #2;
        chk("rst_vld", 64'(out_vld), 64'(0));
        chk("rst_rdy", 64'(in_rdy), 64'(1));
        chk("rst_res", 64'(res), 64'(0));
        chk("rst_raise", 64'(raise), 64'(0));
        chk("rst_sticky", 64'(sticky), 64'(0));
        step();
        step();
        rst = 1'b0;
        step();

        run_op("mul_1p5",   33'h0_7FC00000, 33'h0_7FC00000, 3'd2, 1'b0, 1'b0, 33'h0_80100000, 11'h0, 1'b0);
        run_op("rnd_rz",    33'h0_7F800001, 33'h0_7F800001, 3'd0, 1'b0, 1'b0, 33'h0_7F800002, RX, 1'b0);
        run_op("rnd_away",  33'h0_7F800001, 33'h0_7F800001, 3'd5, 1'b0, 1'b0, 33'h0_7F800003, RX, 1'b0);
        run_op("rnd_pinf",  33'h0_7F800001, 33'h0_7F800001, 3'd3, 1'b0, 1'b0, 33'h0_7F800003, RX, 1'b0);
        run_op("rnd_minf",  33'h1_7F800001, 33'h0_7F800001, 3'd4, 1'b0, 1'b0, 33'h1_7F800003, RX, 1'b0);
        run_op("tie_away",  33'h0_7F800800, 33'h0_7F800800, 3'd1, 1'b0, 1'b0, 33'h0_7F801001, RX, 1'b0);
        run_op("tie_even",  33'h0_7F800800, 33'h0_7F800800, 3'd2, 1'b0, 1'b0, 33'h0_7F801000, RX, 1'b0);
        run_op("carry_rz",  33'h0_7FFFF448, 33'h0_7F8005DC, 3'd0, 1'b0, 1'b0, 33'h0_7FFFFFFF, RX, 1'b0);
        run_op("carry_up",  33'h0_7FFFF448, 33'h0_7F8005DC, 3'd5, 1'b0, 1'b0, 33'h0_80000000, RX, 1'b0);
        run_op("ovf",       33'h0_FE800000, 33'h0_FE800000, 3'd0, 1'b0, 1'b0, 33'h0_FF000000, RO, 1'b0);
        run_op("unf",       33'h1_00800000, 33'h0_00800000, 3'd0, 1'b0, 1'b0, 33'h1_00000000, RU, 1'b0);
        run_op("inf_zero0", 33'h0_FF000000, 33'h0_00000000, 3'd0, 1'b0, 1'b0, 33'h1_FFC00001, 11'h0, 1'b0);
        run_op("inf_zero1", 33'h0_FF000000, 33'h0_00000000, 3'd0, 1'b1, 1'b0, 33'h1_FF800001, RI, 1'b0);
        run_op("nan_op",    33'h0_FF800000, 33'h0_7FC00000, 3'd0, 1'b0, 1'b0, 33'h1_FFC00001, 11'h0, 1'b0);
        run_op("inf_fin",   33'h0_FF000000, 33'h1_7FC00000, 3'd0, 1'b0, 1'b0, 33'h1_FF000000, 11'h0, 1'b0);
        run_op("zero_fin",  33'h1_00000000, 33'h0_7FC00000, 3'd0, 1'b0, 1'b0, 33'h1_00000000, 11'h0, 1'b0);
        run_op("copy_a",    33'h0_FF800000, 33'h0_00000000, 3'd0, 1'b1, 1'b1, 33'h0_FF800000, 11'h0, 1'b0);
        run_op("clr_wins",  33'h0_FE800000, 33'h0_FE800000, 3'd0, 1'b0, 1'b0, 33'h0_FF000000, RO, 1'b1);

        // Six back-to-back ops, consumer stalls in cycles 4..8
        k = 0; got = 0; held_v = 1'b0; held_res = '0;
        for (int c = 0; c < 40; c++) begin
            out_rdy = !(c >= 4 && c <= 8);
            if (k < 6) begin
                in_vld = 1'b1;
                A      = 33'h0_7F800000;
                B      = 33'h0_7F800000 + 33'(k + 1);
            end else begin
                in_vld = 1'b0;
            end
            #1;
            if (c >= 4 && c <= 8) begin
                chk("stall_vld", 64'(out_vld), 64'(1));
                chk("stall_rdy", 64'(in_rdy), 64'(0));
            end
            if (out_vld) begin
                if (!out_rdy) begin
                    if (held_v) chk("stall_hold", 64'(res), 64'(held_res));
                    held_v   = 1'b1;
                    held_res = res;
                end else begin
                    chk("order", 64'(res), 64'(33'h0_7F800000 + 33'(got + 1)));
                    got++;
                    held_v = 1'b0;
                end
            end else begin
                held_v = 1'b0;
            end
            acc = in_vld & in_rdy;
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        chk("stream_count", 64'(got), 64'(6));
        chk("stream_sticky", 64'(sticky), 64'(exp_sticky));

        // Flush with two ops in flight and a third offered in the flush cycle
        A = 33'h0_7F800000; B = 33'h0_7F800001; in_vld = 1'b1;
        step();
        B = 33'h0_7F800002;
        step();
        B = 33'h0_7F800003; flush = 1'b1;
        step();
        flush = 1'b0; in_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("flush_novld", 64'(out_vld), 64'(0));
            step();
        end
        chk("flush_sticky", 64'(sticky), 64'(exp_sticky));

        // Reset with two ops in flight and a third offered
        A = 33'h0_7FC00000; B = 33'h0_7FC00000; rmode = 3'd2; in_vld = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", 64'(out_vld), 64'(0));
        chk("mid_rst_rdy", 64'(in_rdy), 64'(1));
        chk("mid_rst_sticky", 64'(sticky), 64'(0));
        step();
        step();
        rst = 1'b0; in_vld = 1'b0; rmode = 3'd0; exp_sticky = '0;
        for (int i = 0; i < 5; i++) begin
            chk("rst_novld", 64'(out_vld), 64'(0));
            step();
        end
        run_op("post_rst", 33'h0_7FC00000, 33'h0_7FC00000, 3'd2, 1'b0, 1'b0, 33'h0_80100000, 11'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
